// File: rtl/load_store_buffer_pkg.sv
// Shared definitions for the load/store buffer: memory op codes, access sizes,
// head FSM states and small decode/extension helpers.
package load_store_buffer_pkg;

    localparam logic [4:0] OP_LB  = 5'h0B;
    localparam logic [4:0] OP_LH  = 5'h0C;
    localparam logic [4:0] OP_LW  = 5'h0D;
    localparam logic [4:0] OP_LBU = 5'h0E;
    localparam logic [4:0] OP_LHU = 5'h0F;
    localparam logic [4:0] OP_SB  = 5'h10;
    localparam logic [4:0] OP_SH  = 5'h11;
    localparam logic [4:0] OP_SW  = 5'h12;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LD_BUSY = 2'd1,
        ST_WAIT = 2'd2,
        ST_BUSY = 2'd3
    } lsb_state_t;

    function automatic logic is_load(input logic [4:0] op);
        logic result;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: result = 1'b1;
            default:                             result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        logic result;
        case (op)
            OP_SB, OP_SH, OP_SW: result = 1'b1;
            default:             result = 1'b0;
        endcase
        return result;
    endfunction

    function automatic logic [1:0] op_size(input logic [4:0] op);
        logic [1:0] result;
        case (op)
            OP_LB, OP_LBU, OP_SB: result = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: result = SIZE_HALF;
            default:              result = SIZE_WORD;
        endcase
        return result;
    endfunction

    // Memory returns data right-aligned; widen it according to the load flavour.
    function automatic logic [31:0] load_extend(input logic [4:0] op, input logic [31:0] rdata);
        logic [31:0] result;
        case (op)
            OP_LB:   result = {{24{rdata[7]}}, rdata[7:0]};
            OP_LH:   result = {{16{rdata[15]}}, rdata[15:0]};
            OP_LBU:  result = {24'h000000, rdata[7:0]};
            OP_LHU:  result = {16'h0000, rdata[15:0]};
            default: result = rdata;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/load_store_buffer_fifo.sv
// Circular entry storage for the load/store buffer with head/tail pointers,
// occupancy count and a registered full flag.
module lsb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 72
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             flush,
    input  logic             keep_head,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    head_ptr;
    logic [PW-1:0]    tail_ptr;
    logic [PW-1:0]    head_n;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_n;
    logic             push_ok;
    logic             pop_ok;
    logic             full_q;

    // A push against a full queue is dropped even if the head leaves this cycle.
    assign push_ok = push && (count != MAX_CNT) && !flush;
    assign pop_ok  = pop && (count != '0);
    assign head_n  = pop_ok ? head_ptr + 1'b1 : head_ptr;

    always_comb begin
        count_n = count;
        if (flush) begin
            count_n = (keep_head && !pop_ok && (count != '0)) ? ONE_CNT : '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10:   count_n = count + 1'b1;
                2'b01:   count_n = count - 1'b1;
                default: count_n = count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
            full_q   <= 1'b0;
        end else begin
            head_ptr <= head_n;
            count    <= count_n;
            full_q   <= (count_n == MAX_CNT);
            if (flush) begin
                tail_ptr <= (count_n == ONE_CNT) ? head_n + 1'b1 : head_n;
            end else if (push_ok) begin
                tail_ptr <= tail_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[tail_ptr] <= wr_data;
        end
    end

    assign rd_data = mem[head_ptr];
    assign empty   = (count == '0);
    assign full    = full_q;

endmodule

// File: rtl/load_store_buffer.sv
// In-order load/store queue between the address unit and data memory; issues one
// access at a time, holds stores until commit and broadcasts results on the CDB.
module load_store_buffer
    import load_store_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ROB_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      addr_in,
    input  logic [4:0]       op_in,
    input  logic [ROB_W-1:0] rob_in,
    input  logic [31:0]      data_in,
    input  logic             flush,
    input  logic             commit_valid,
    input  logic [ROB_W-1:0] commit_rob,
    output logic             full,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [1:0]       mem_size,
    input  logic             mem_ready,
    input  logic [31:0]      mem_rdata,
    output logic             cdb_valid,
    output logic [ROB_W-1:0] cdb_rob,
    output logic [31:0]      cdb_value
);

    localparam int EW = 32 + 5 + ROB_W + 32;

    logic [EW-1:0]    head_entry;
    logic [31:0]      head_addr;
    logic [4:0]       head_op;
    logic [ROB_W-1:0] head_rob;
    logic [31:0]      head_data;
    logic             empty;
    logic             pop;

    lsb_state_t       state, state_n;
    logic             announced, announced_n;
    logic             ld_flushed, ld_flushed_n;
    logic             mem_req_n, mem_we_n;
    logic [31:0]      mem_addr_n, mem_wdata_n;
    logic [1:0]       mem_size_n;
    logic             cdb_valid_n;
    logic [ROB_W-1:0] cdb_rob_n;
    logic [31:0]      cdb_value_n;

    lsb_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rob_in != '0),
        .wr_data   ({addr_in, op_in, rob_in, data_in}),
        .pop       (pop),
        .flush     (flush),
        .keep_head (state == ST_BUSY),
        .rd_data   (head_entry),
        .empty     (empty),
        .full      (full)
    );

    assign head_addr = head_entry[EW-1 -: 32];
    assign head_op   = head_entry[32+ROB_W +: 5];
    assign head_rob  = head_entry[32 +: ROB_W];
    assign head_data = head_entry[31:0];

    // Head FSM: memory outputs hold their value unless a transition changes them.
    // A load flushed mid-flight still waits for its response, which is then dropped.
    always_comb begin
        state_n      = state;
        announced_n  = announced;
        ld_flushed_n = ld_flushed;
        mem_req_n    = mem_req;
        mem_we_n     = mem_we;
        mem_addr_n   = mem_addr;
        mem_wdata_n  = mem_wdata;
        mem_size_n   = mem_size;
        cdb_valid_n  = 1'b0;
        cdb_rob_n    = '0;
        cdb_value_n  = '0;
        pop          = 1'b0;

        case (state)
            IDLE: begin
                if (!empty && !flush) begin
                    if (is_load(head_op)) begin
                        state_n     = LD_BUSY;
                        mem_req_n   = 1'b1;
                        mem_we_n    = 1'b0;
                        mem_addr_n  = head_addr;
                        mem_wdata_n = '0;
                        mem_size_n  = op_size(head_op);
                    end else if (is_store(head_op)) begin
                        if (!announced) begin
                            cdb_valid_n = 1'b1;
                            cdb_rob_n   = head_rob;
                            announced_n = 1'b1;
                            state_n     = ST_WAIT;
                        end
                    end else begin
                        cdb_valid_n = 1'b1;
                        cdb_rob_n   = head_rob;
                        pop         = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (flush) begin
                    state_n = IDLE;
                end else if (commit_valid && (commit_rob == head_rob)) begin
                    state_n     = ST_BUSY;
                    mem_req_n   = 1'b1;
                    mem_we_n    = 1'b1;
                    mem_addr_n  = head_addr;
                    mem_wdata_n = head_data;
                    mem_size_n  = op_size(head_op);
                end
            end
            LD_BUSY: begin
                if (mem_ready) begin
                    state_n      = IDLE;
                    announced_n  = 1'b0;
                    ld_flushed_n = 1'b0;
                    mem_req_n    = 1'b0;
                    mem_we_n     = 1'b0;
                    mem_addr_n   = '0;
                    mem_wdata_n  = '0;
                    mem_size_n   = '0;
                    if (!ld_flushed && !flush) begin
                        cdb_valid_n = 1'b1;
                        cdb_rob_n   = head_rob;
                        cdb_value_n = load_extend(head_op, mem_rdata);
                        pop         = 1'b1;
                    end
                end else if (flush) begin
                    ld_flushed_n = 1'b1;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    state_n     = IDLE;
                    announced_n = 1'b0;
                    mem_req_n   = 1'b0;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = '0;
                    mem_wdata_n = '0;
                    mem_size_n  = '0;
                    pop         = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        if (flush) begin
            announced_n = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            announced  <= 1'b0;
            ld_flushed <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_size   <= '0;
            cdb_valid  <= 1'b0;
            cdb_rob    <= '0;
            cdb_value  <= '0;
        end else begin
            state      <= state_n;
            announced  <= announced_n;
            ld_flushed <= ld_flushed_n;
            mem_req    <= mem_req_n;
            mem_we     <= mem_we_n;
            mem_addr   <= mem_addr_n;
            mem_wdata  <= mem_wdata_n;
            mem_size   <= mem_size_n;
            cdb_valid  <= cdb_valid_n;
            cdb_rob    <= cdb_rob_n;
            cdb_value  <= cdb_value_n;
        end
    end

endmodule

// File: tb/tb_load_store_buffer.sv
// Directed self-checking bench for load_store_buffer: load extension, store commit
// handshake, full back-pressure, flush in both busy states and mid-operation reset.
module tb_load_store_buffer;

    localparam logic [4:0] LB  = 5'h0B;
    localparam logic [4:0] LH  = 5'h0C;
    localparam logic [4:0] LW  = 5'h0D;
    localparam logic [4:0] LBU = 5'h0E;
    localparam logic [4:0] LHU = 5'h0F;
    localparam logic [4:0] SW  = 5'h12;

    logic        clk;
    logic        rst;
    logic [31:0] addr_in;
    logic [4:0]  op_in;
    logic [2:0]  rob_in;
    logic [31:0] data_in;
    logic        flush;
    logic        commit_valid;
    logic [2:0]  commit_rob;
    logic        full;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        cdb_valid;
    logic [2:0]  cdb_rob;
    logic [31:0] cdb_value;

    int checks;
    int passes;

    logic [4:0]  ld_ops   [5] = '{LB, LBU, LH, LHU, LW};
    logic [31:0] ld_addr  [5] = '{32'h100, 32'h100, 32'h102, 32'h102, 32'h104};
    logic [31:0] ld_rdata [5] = '{32'h000000F0, 32'h000000F0, 32'h12348001, 32'h12348001, 32'h12348001};
    logic [31:0] ld_exp   [5] = '{32'hFFFFFFF0, 32'h000000F0, 32'hFFFF8001, 32'h00008001, 32'h12348001};
    logic [1:0]  ld_size  [5] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2};

    load_store_buffer #(.DEPTH(4), .ROB_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr_in      (addr_in),
        .op_in        (op_in),
        .rob_in       (rob_in),
        .data_in      (data_in),
        .flush        (flush),
        .commit_valid (commit_valid),
        .commit_rob   (commit_rob),
        .full         (full),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_size     (mem_size),
        .mem_ready    (mem_ready),
        .mem_rdata    (mem_rdata),
        .cdb_valid    (cdb_valid),
        .cdb_rob      (cdb_rob),
        .cdb_value    (cdb_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic [31:0] a, input logic [4:0] op, input logic [2:0] rob,
                       input logic [31:0] d);
        addr_in = a;
        op_in   = op;
        rob_in  = rob;
        data_in = d;
        step();
        addr_in = '0;
        op_in   = '0;
        rob_in  = '0;
        data_in = '0;
    endtask

    task automatic wait_req(input int limit);
        int n = 0;
        while (mem_req !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic wait_cdb(input int limit);
        int n = 0;
        while (cdb_valid !== 1'b1 && n < limit) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if ({full, mem_req, mem_we, mem_size, cdb_valid, cdb_rob} !== '0 || mem_addr !== '0 ||
            mem_wdata !== '0 || cdb_value !== '0)
            $display("[TB] FAIL reset_outputs: got req=%0b full=%0b cdb=%0b, want all zero",
                     mem_req, full, cdb_valid);
        else passes++;
        rst = 1'b0;
        step();
        checks++;
        if (mem_req !== 1'b0 || cdb_valid !== 1'b0)
            $display("[TB] FAIL reset_idle: got req=%0b cdb=%0b, want 0/0", mem_req, cdb_valid);
        else passes++;
    endtask

    task automatic test_load_ext();
        for (int i = 0; i < 5; i++) begin
            enq(ld_addr[i], ld_ops[i], 3'(i + 1), 32'hFFFFFFFF);
            wait_req(10);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b0)
                $display("[TB] FAIL ld%0d_req: got req=%0b we=%0b, want 1/0", i, mem_req, mem_we);
            else passes++;
            checks++;
            if (mem_addr !== ld_addr[i] || mem_size !== ld_size[i])
                $display("[TB] FAIL ld%0d_addr: got %h size %0d, want %h size %0d",
                         i, mem_addr, mem_size, ld_addr[i], ld_size[i]);
            else passes++;
            step();
            checks++;
            if (mem_req !== 1'b1 || mem_addr !== ld_addr[i] || cdb_valid !== 1'b0)
                $display("[TB] FAIL ld%0d_hold: got req=%0b addr=%h cdb=%0b, want 1 %h 0",
                         i, mem_req, mem_addr, cdb_valid, ld_addr[i]);
            else passes++;
            mem_ready = 1'b1;
            mem_rdata = ld_rdata[i];
            step();
            mem_ready = 1'b0;
            mem_rdata = '0;
            checks++;
            if (cdb_valid !== 1'b1 || cdb_rob !== 3'(i + 1))
                $display("[TB] FAIL ld%0d_cdb: got valid=%0b rob=%0d, want 1 %0d",
                         i, cdb_valid, cdb_rob, i + 1);
            else passes++;
            checks++;
            if (cdb_value !== ld_exp[i])
                $display("[TB] FAIL ld%0d_value: got %h, want %h", i, cdb_value, ld_exp[i]);
            else passes++;
            checks++;
            if (mem_req !== 1'b0)
                $display("[TB] FAIL ld%0d_drop: got req=%0b, want 0", i, mem_req);
            else passes++;
            step();
            checks++;
            if (cdb_valid !== 1'b0)
                $display("[TB] FAIL ld%0d_pulse: got cdb_valid=%0b, want 0", i, cdb_valid);
            else passes++;
        end
    endtask

    task automatic test_other_op();
        enq(32'h0, 5'h01, 3'd7, 32'h1234);
        wait_cdb(10);
        checks++;
        if (cdb_valid !== 1'b1 || cdb_rob !== 3'd7 || cdb_value !== 32'h0)
            $display("[TB] FAIL other_cdb: got valid=%0b rob=%0d val=%h, want 1 7 0",
                     cdb_valid, cdb_rob, cdb_value);
        else passes++;
        step();
        checks++;
        if (cdb_valid !== 1'b0 || mem_req !== 1'b0)
            $display("[TB] FAIL other_done: got cdb=%0b req=%0b, want 0/0", cdb_valid, mem_req);
        else passes++;
    endtask

    task automatic test_store();
        logic saw_req = 1'b0;
        logic saw_cdb = 1'b0;
        enq(32'h200, SW, 3'd3, 32'hDEADBEEF);
        wait_cdb(10);
        checks++;
        if (cdb_valid !== 1'b1 || cdb_rob !== 3'd3 || cdb_value !== 32'h0)
            $display("[TB] FAIL st_announce: got valid=%0b rob=%0d val=%h, want 1 3 0",
                     cdb_valid, cdb_rob, cdb_value);
        else passes++;
        for (int c = 0; c < 5; c++) begin
            step();
            saw_req |= mem_req;
            saw_cdb |= cdb_valid;
        end
        checks++;
        if (saw_req !== 1'b0 || saw_cdb !== 1'b0)
            $display("[TB] FAIL st_wait: got req=%0b cdb=%0b before commit, want 0/0",
                     saw_req, saw_cdb);
        else passes++;
        commit_valid = 1'b1;
        commit_rob   = 3'd2;
        step();
        commit_valid = 1'b0;
        step();
        checks++;
        if (mem_req !== 1'b0)
            $display("[TB] FAIL st_wrong_tag: got req=%0b, want 0", mem_req);
        else passes++;
        commit_valid = 1'b1;
        commit_rob   = 3'd3;
        step();
        commit_valid = 1'b0;
        commit_rob   = '0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_size !== 2'd2)
            $display("[TB] FAIL st_issue: got req=%0b we=%0b size=%0d, want 1 1 2",
                     mem_req, mem_we, mem_size);
        else passes++;
        checks++;
        if (mem_addr !== 32'h200 || mem_wdata !== 32'hDEADBEEF)
            $display("[TB] FAIL st_payload: got %h/%h, want 00000200/deadbeef", mem_addr, mem_wdata);
        else passes++;
        step();
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        checks++;
        if (mem_req !== 1'b0 || cdb_valid !== 1'b0)
            $display("[TB] FAIL st_done: got req=%0b cdb=%0b, want 0/0", mem_req, cdb_valid);
        else passes++;
        step();
        step();
        checks++;
        if (mem_req !== 1'b0)
            $display("[TB] FAIL st_empty: got req=%0b, want 0", mem_req);
        else passes++;
    endtask

    task automatic test_full();
        logic [2:0]  tags [8];
        logic [31:0] vals [8];
        int n = 0;
        for (int i = 0; i < 4; i++) enq(32'h300 + 32'(4 * i), LW, 3'(i + 1), '0);
        checks++;
        if (full !== 1'b1)
            $display("[TB] FAIL full_set: got %0b, want 1", full);
        else passes++;
        enq(32'h3F0, LW, 3'd5, '0);
        checks++;
        if (full !== 1'b1)
            $display("[TB] FAIL full_hold: got %0b, want 1", full);
        else passes++;
        for (int c = 0; c < 60; c++) begin
            if (mem_req === 1'b1 && mem_ready === 1'b0) begin
                mem_ready = 1'b1;
                mem_rdata = mem_addr;
            end else begin
                mem_ready = 1'b0;
                mem_rdata = '0;
            end
            step();
            if (cdb_valid === 1'b1) begin
                if (n < 8) begin
                    tags[n] = cdb_rob;
                    vals[n] = cdb_value;
                end
                n++;
            end
        end
        mem_ready = 1'b0;
        checks++;
        if (n != 4)
            $display("[TB] FAIL full_count: got %0d broadcasts, want 4", n);
        else passes++;
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (tags[i] !== 3'(i + 1) || vals[i] !== 32'h300 + 32'(4 * i))
                $display("[TB] FAIL full_order%0d: got rob %0d val %h, want rob %0d val %h",
                         i, tags[i], vals[i], i + 1, 32'h300 + 32'(4 * i));
            else passes++;
        end
        checks++;
        if (full !== 1'b0)
            $display("[TB] FAIL full_clear: got %0b, want 0", full);
        else passes++;
    endtask

    task automatic test_flush_ld();
        logic saw_req = 1'b0;
        logic saw_cdb = 1'b0;
        for (int i = 0; i < 3; i++) enq(32'h700 + 32'(4 * i), LW, 3'(i + 1), '0);
        wait_req(10);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h700)
            $display("[TB] FAIL fld_issue: got req=%0b addr=%h, want 1 00000700", mem_req, mem_addr);
        else passes++;
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
        step();
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h700 || mem_size !== 2'd2)
            $display("[TB] FAIL fld_hold: got req=%0b addr=%h, want 1 00000700", mem_req, mem_addr);
        else passes++;
        mem_ready = 1'b1;
        mem_rdata = 32'h11111111;
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
        for (int c = 0; c < 12; c++) begin
            saw_req |= mem_req;
            saw_cdb |= cdb_valid;
            step();
        end
        checks++;
        if (saw_cdb !== 1'b0 || saw_req !== 1'b0 || full !== 1'b0)
            $display("[TB] FAIL fld_quiet: got cdb=%0b req=%0b full=%0b, want 0/0/0",
                     saw_cdb, saw_req, full);
        else passes++;
        enq(32'h7A0, LW, 3'd6, '0);
        wait_req(10);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h7A0)
            $display("[TB] FAIL fld_next_issue: got req=%0b addr=%h, want 1 000007a0",
                     mem_req, mem_addr);
        else passes++;
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADF00D;
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_rob !== 3'd6 || cdb_value !== 32'h0BADF00D)
            $display("[TB] FAIL fld_next_cdb: got valid=%0b rob=%0d val=%h, want 1 6 0badf00d",
                     cdb_valid, cdb_rob, cdb_value);
        else passes++;
        step();
    endtask

    task automatic test_flush_st();
        logic saw_req = 1'b0;
        logic saw_cdb = 1'b0;
        enq(32'h400, SW, 3'd2, 32'h55AA55AA);
        enq(32'h404, LW, 3'd4, '0);
        wait_cdb(10);
        checks++;
        if (cdb_valid !== 1'b1 || cdb_rob !== 3'd2)
            $display("[TB] FAIL fst_announce: got valid=%0b rob=%0d, want 1 2", cdb_valid, cdb_rob);
        else passes++;
        step();
        commit_valid = 1'b1;
        commit_rob   = 3'd2;
        step();
        commit_valid = 1'b0;
        commit_rob   = '0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h400 || mem_wdata !== 32'h55AA55AA)
            $display("[TB] FAIL fst_inflight: got req=%0b we=%0b addr=%h data=%h, want 1 1 00000400 55aa55aa",
                     mem_req, mem_we, mem_addr, mem_wdata);
        else passes++;
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            saw_req |= mem_req;
            saw_cdb |= cdb_valid;
            step();
        end
        checks++;
        if (saw_req !== 1'b0 || saw_cdb !== 1'b0 || full !== 1'b0)
            $display("[TB] FAIL fst_empty: got req=%0b cdb=%0b full=%0b, want 0/0/0",
                     saw_req, saw_cdb, full);
        else passes++;
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) enq(32'h500 + 32'(4 * i), LW, 3'(i + 1), '0);
        wait_req(10);
        checks++;
        if (mem_req !== 1'b1 || full !== 1'b1)
            $display("[TB] FAIL rmid_pre: got req=%0b full=%0b, want 1/1", mem_req, full);
        else passes++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({full, mem_req, mem_we, mem_size, cdb_valid, cdb_rob} !== '0 || mem_addr !== '0 ||
            mem_wdata !== '0 || cdb_value !== '0)
            $display("[TB] FAIL rmid_zero: got req=%0b full=%0b addr=%h size=%0d, want all zero",
                     mem_req, full, mem_addr, mem_size);
        else passes++;
        enq(32'h600, LW, 3'd2, '0);
        wait_req(10);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h600 || mem_size !== 2'd2)
            $display("[TB] FAIL rmid_issue: got req=%0b addr=%h size=%0d, want 1 00000600 2",
                     mem_req, mem_addr, mem_size);
        else passes++;
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        step();
        mem_ready = 1'b0;
        mem_rdata = '0;
        checks++;
        if (cdb_valid !== 1'b1 || cdb_rob !== 3'd2 || cdb_value !== 32'hCAFEF00D)
            $display("[TB] FAIL rmid_cdb: got valid=%0b rob=%0d val=%h, want 1 2 cafef00d",
                     cdb_valid, cdb_rob, cdb_value);
        else passes++;
        step();
    endtask

    initial begin
        checks       = 0;
        passes       = 0;
        rst          = 1'b1;
        addr_in      = '0;
        op_in        = '0;
        rob_in       = '0;
        data_in      = '0;
        flush        = 1'b0;
        commit_valid = 1'b0;
        commit_rob   = '0;
        mem_ready    = 1'b0;
        mem_rdata    = '0;
        test_reset();
        test_load_ext();
        test_other_op();
        test_store();
        test_full();
        test_flush_ld();
        test_flush_st();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule
